usb_rst_sequencer: RTL
======================

# usb_rst_sequencer

Sits directly downstream of the one-bit USB reset PIO register on the Avalon bus and turns its software-written level into a correctly timed reset for the board's USB interface chip. It guarantees a minimum reset pulse width and a post-reset wake-up delay regardless of how briefly software toggles the PIO bit. It also performs an automatic power-on reset of the chip and exposes ready/busy status and a sequence counter that can be read back through a PIO input.

## Interface
Parameters:
- RST_CYCLES, 500: minimum clocks usb_rst_n is held low per sequence (10 us at 50 MHz); legal range ≥ 1.
- WAKE_CYCLES, 2500: clocks after usb_rst_n release before usb_ready asserts (50 us at 50 MHz); legal range ≥ 1.
- CNT_W, 16: width of the internal delay counter; must satisfy 2^CNT_W > max(RST_CYCLES, WAKE_CYCLES).

Ports:
- clk, input, 1: system clock; single clock domain for the whole block.
- reset, input, 1: synchronous, active-high reset.
- rst_req, input, 1: reset request level from the PIO out_port. Same clock domain, so no synchronizer is used.
- usb_rst_n, output, 1: active-low reset pin to the USB chip; registered.
- usb_ready, output, 1: high when the chip is out of reset and its wake-up delay has elapsed; registered.
- busy, output, 1: high in every state except IDLE; registered.
- seq_count, output, 8: count of completed sequences; wraps modulo 256; registered.

## Operation
- States:
  - ASSERT: usb_rst_n = 0.
  - HOLD: usb_rst_n = 0; software is still holding rst_req high.
  - RECOVER: usb_rst_n = 1, usb_ready = 0.
  - IDLE: usb_rst_n = 1, usb_ready = 1.
- Reset values: state = ASSERT, cnt = 0, usb_rst_n = 0, usb_ready = 0, busy = 1, seq_count = 0, rst_req_d = 0. The chip is therefore reset automatically at power-on.
- Edge detect: rise = rst_req & ~rst_req_d. The rst_req_d register samples rst_req every cycle.
- ASSERT: cnt increments each cycle. When cnt == RST_CYCLES-1:
  - if rst_req = 1, go to HOLD;
  - otherwise go to RECOVER with cnt cleared.
- HOLD: stay while rst_req = 1. When rst_req is sampled 0, go to RECOVER with cnt cleared.
- RECOVER: cnt increments each cycle. When cnt == WAKE_CYCLES-1, go to IDLE and increment seq_count.
- IDLE: on rise, go to ASSERT with cnt cleared.
- Retrigger: a rise in RECOVER goes to ASSERT with cnt cleared. seq_count is not incremented for the aborted sequence.
- Edges seen in ASSERT or HOLD are ignored; the pulse is already active.
- seq_count arithmetic: 8-bit unsigned, 255 + 1 → 0. No saturation.
- Counter: CNT_W bits, compared for equality only. It never wraps within legal parameters.
- Outputs are decoded from the next state and registered, so each output changes on the same edge as the state.

## Timing
- Latency: a rst_req rising edge sampled at posedge k drives usb_rst_n low from posedge k. Zero added cycles after the sampling edge.
- Minimum pulse: usb_rst_n stays low for exactly RST_CYCLES clocks when rst_req is a 1-cycle pulse. It stays low for max(RST_CYCLES, rst_req high duration) clocks when rst_req is held.
- Release from HOLD: usb_rst_n rises on the posedge that samples rst_req = 0.
- Wake-up: usb_ready rises exactly WAKE_CYCLES clocks after usb_rst_n rises. seq_count updates on the same edge. busy falls on the same edge.
- Post-reset: usb_rst_n stays low for the whole time reset is high. It then stays low for RST_CYCLES further posedges with reset = 0, and rises on the RST_CYCLES-th one.
- Reset mid-sequence, in any state: the next posedge restores all reset values, including seq_count = 0. A new automatic sequence starts.
- Simultaneous rise and RECOVER terminal count: rise wins. The block goes to ASSERT and seq_count is unchanged.

## Test plan
Test parameters: RST_CYCLES = 4, WAKE_CYCLES = 6.
- Power-on: reset high for 2 cycles, rst_req = 0 → usb_rst_n low through reset plus 4 cycles; usb_ready rises 6 cycles later; seq_count = 1; busy = 0.
- Short request: 1-cycle rst_req pulse in IDLE → usb_rst_n low exactly 4 cycles; usb_ready low for 10 cycles; seq_count = 2.
- Held request: rst_req high for 20 cycles → usb_rst_n low for 20 cycles, rising on the edge that samples rst_req = 0; usb_ready rises 6 cycles later.
- Retrigger: rst_req pulse on the 3rd cycle of RECOVER → new 4-cycle low pulse; usb_ready only after a full 6-cycle RECOVER; seq_count increments by exactly 1.
- Reset mid-RECOVER: with seq_count = 5, assert reset for 1 cycle → usb_rst_n = 0, usb_ready = 0, seq_count = 0 on the next edge; the automatic sequence then completes with seq_count = 1.
- Wrap: 256 back-to-back completed sequences after power-on → seq_count reads 0 after the 255th request, i.e. 256 completions including power-on.

Source files
------------

// File: rtl/usb_rst_sequencer.sv
// Turns the software reset-request level into a timed reset pulse plus wake-up delay for the
// USB interface chip, with power-on reset, ready/busy status and a completed-sequence counter.
module usb_rst_sequencer #(
    parameter int unsigned RST_CYCLES  = 500,
    parameter int unsigned WAKE_CYCLES = 2500,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst_req,
    output logic       usb_rst_n,
    output logic       usb_ready,
    output logic       busy,
    output logic [7:0] seq_count
);

    typedef enum logic [1:0] {
        StAssert,
        StHold,
        StRecover,
        StIdle
    } state_e;

    localparam logic [CNT_W-1:0] RstLast  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seq_q, seq_d;
    logic             rst_req_d;
    logic             rise;
    logic             rst_n_q, ready_q, busy_q;

    assign rise = rst_req & ~rst_req_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        seq_d   = seq_q;
        unique case (state_q)
            StAssert: begin
                if (cnt_q == RstLast) begin
                    if (rst_req) begin
                        state_d = StHold;
                        cnt_d   = cnt_q;
                    end else begin
                        state_d = StRecover;
                        cnt_d   = '0;
                    end
                end
            end
            StHold: begin
                cnt_d = cnt_q;
                if (!rst_req) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                end
            end
            StRecover: begin
                // A new request aborts the wake-up wait, even on its final cycle.
                if (rise) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                end else if (cnt_q == WakeLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    seq_d   = seq_q + 8'd1;
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = StAssert;
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StAssert;
            cnt_q     <= '0;
            seq_q     <= '0;
            rst_req_d <= 1'b0;
            rst_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            rst_req_d <= rst_req;
            rst_n_q   <= (state_d == StRecover) || (state_d == StIdle);
            ready_q   <= (state_d == StIdle);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign usb_rst_n = rst_n_q;
    assign usb_ready = ready_q;
    assign busy      = busy_q;
    assign seq_count = seq_q;

endmodule
